dvsd_pe_evq: RTL and testbench
==============================

# dvsd_pe_evq

Event queue that sits directly downstream of the 8-to-3 priority encoder `dvsd_pe`. It samples the encoder's `out`/`gs`/`eno` every clock and turns each new highest-priority request, or change of it, into one queued event. Events are buffered in a small FIFO and drained by a consumer over a valid/ready handshake, with sticky overflow reporting.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `code` input 3: encoder `out`; index of the highest-priority active request.
- `gs` input 1: encoder group-select; 1 = at least one request active and encoder enabled.
- `eno` input 1: encoder enable-out; 1 = encoder enabled with no request active (idle).
- `evt_valid` output 1: head entry available.
- `evt_ready` input 1: consumer accepts head entry.
- `evt_code` output 3: head entry's code.
- `level` output $clog2(DEPTH)+1: entries held.
- `idle` output 1: registered copy of `eno`.
- `ovf` output 1: sticky; an event was dropped because the FIFO was full.
- `ovf_clr` input 1: synchronous clear of `ovf` (and `ovf_cnt`).
- `ovf_cnt` output 8: dropped-event count (see Configuration).

## Operation
- Sample registers `code_q` (3b) and `gs_q` (1b) load `code` and `gs` on every edge.
- New event: `new_evt = gs & (!gs_q | (code != code_q))`. A held request produces exactly one event. A new highest priority, or a return after `gs` drops, produces another. `gs` falling produces no event.
- Push: on an edge where `new_evt` = 1, `code` is written at the write pointer.
- Pop: on an edge where `evt_valid & evt_ready`, the read pointer advances.
- Full (`level == DEPTH`) with push and no pop: the event is dropped, `ovf` sets, `ovf_cnt` increments (saturating at 255). The FIFO is unchanged.
- Full with push and pop on the same edge: both take effect, `level` stays DEPTH, no overflow.
- Empty with push and no pop: `level` becomes 1. A pop while empty cannot occur because `evt_valid` = 0.
- Pointers wrap modulo DEPTH. `level` is tracked separately, range 0..DEPTH.
- `ovf_clr` has priority over a same-cycle overflow: `ovf` reads 0 afterwards and the dropped event is not counted.
- `evt_code` is driven from the head entry. It is undefined-but-stable when `evt_valid` = 0; drive 0.
- Unknown or X on `code` is not checked. Consumers rely only on `gs`.

## Timing
- Reset values: `code_q`=0, `gs_q`=0, pointers=0, `level`=0, `evt_valid`=0, `evt_code`=0, `idle`=0, `ovf`=0, `ovf_cnt`=0.
- Latency: a request visible on `gs`/`code` before edge k is pushed at edge k. `evt_valid` is 1 after edge k, so an event is visible one cycle after the encoder output.
- Throughput: one push and one pop per cycle.
- Handshake:
  - `evt_valid` never drops without a pop.
  - `evt_code` is stable while `evt_valid & !evt_ready`.
  - `evt_ready` may be held high permanently.
- Reset mid-operation: all queued events and the sticky flags are lost immediately. The first edge after reset release treats any active `gs` as a new event, because `gs_q` = 0.
- `level`, `idle`, `ovf` and `ovf_cnt` are all registered. There are no combinational paths from inputs to outputs, except `evt_valid`/`evt_code`, which come from FIFO state only.

## Configuration
- `DVSD_PE_EVQ_OVF_CNT_EN`:
  - Defined: the 8-bit saturating drop counter is built, and `ovf_cnt` reports it, cleared by `ovf_clr`.
  - Undefined: there is no counter logic and `ovf_cnt` is tied to 0. The `ovf` flag exists in both builds.

## Structure
- Package `dvsd_pe_pkg`:
  - `CODE_W` = 3 and `REQ_W` = 8.
  - typedef `pe_code_t` (logic [CODE_W-1:0]).
  - constant `OVF_CNT_MAX` = 8'hFF.
- Sub-module `dvsd_pe_evq_fifo`: parameterised DEPTH storage, pointers, `level`, full/empty.
- The top level holds the sample registers, event detection, the overflow flag and the counter.

## Test plan
- Reset: assert `rst_n`=0 mid-traffic with 3 entries queued -> all outputs return to their reset values asynchronously, and `level`=0.
- Single held request: `gs`=1, `code`=5 for 10 cycles, `evt_ready`=0 -> exactly one entry, `evt_code`=5, `level`=1, visible 1 cycle after `gs` rises.
- Priority walk: `code` steps 0,1,...,7 one per cycle with `gs`=1 and `evt_ready`=1 -> consumer receives 0..7 in order, one per cycle, `level` never exceeds 1.
- Overflow (DEPTH=4, `evt_ready`=0): codes 1,2,3,4,5,6 -> FIFO holds 1..4, `ovf`=1, `ovf_cnt`=2 with the macro defined (0 without). Then `ovf_clr` -> `ovf`=0, `ovf_cnt`=0.
- Full push+pop: FIFO full, new code 7 with `evt_ready`=1 in the same cycle -> head popped, 7 enqueued, `level`=4, `ovf`=0.
- Idle and gs drop: `eno`=1, `gs`=0 -> `idle`=1 next cycle, no push. `gs` 1→0→1 with the same `code`=3 -> two events of code 3.

Source files
------------

// File: rtl/dvsd_pe_pkg.sv
// Shared types and constants for the dvsd_pe priority encoder and its event queue.
package dvsd_pe_pkg;
   localparam int CODE_W = 3;
   localparam int REQ_W  = 8;

   typedef logic [CODE_W-1:0] pe_code_t;

   localparam logic [7:0] OVF_CNT_MAX = 8'hFF;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == OVF_CNT_MAX) ? v : v + 8'd1;
   endfunction
endpackage

// File: rtl/dvsd_pe_evq_fifo.sv
// Event FIFO for dvsd_pe_evq: DEPTH-entry code storage, wrapping pointers and an explicit fill level.
module dvsd_pe_evq_fifo
   import dvsd_pe_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int LVL_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [CODE_W-1:0] din,
   output logic [CODE_W-1:0] dout,
   output logic              valid,
   output logic              full,
   output logic [LVL_W-1:0]  level
);

   pe_code_t             mem_q [DEPTH];
   pe_code_t             mem_d [DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]     level_q, level_d;
   logic                 push_ok;
   logic                 pop_ok;

   assign valid = (level_q != '0);
   assign full  = (level_q == LVL_W'(DEPTH));
   assign level = level_q;
   assign dout  = valid ? mem_q[rd_ptr_q] : '0;

   // A push into a full FIFO only lands if the head leaves on the same edge.
   assign pop_ok  = pop & valid;
   assign push_ok = push & (~full | pop_ok);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage is data only; the output mux hides it whenever level is 0.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/dvsd_pe_evq.sv
// Event queue behind the dvsd_pe encoder: one event per new highest-priority request, with sticky overflow.
// Optional drop counter built when DVSD_PE_EVQ_OVF_CNT_EN is defined; otherwise ovf_cnt is tied to 0.
module dvsd_pe_evq
   import dvsd_pe_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [2:0]             code,
   input  logic                   gs,
   input  logic                   eno,
   output logic                   evt_valid,
   input  logic                   evt_ready,
   output logic [2:0]             evt_code,
   output logic [$clog2(DEPTH):0] level,
   output logic                   idle,
   output logic                   ovf,
   input  logic                   ovf_clr,
   output logic [7:0]             ovf_cnt
);

   pe_code_t code_q, code_d;
   logic     gs_q, gs_d;
   logic     idle_q, idle_d;
   logic     ovf_q, ovf_d;
   logic     new_evt;
   logic     pop;
   logic     full;
   logic     drop;

   // Rising gs or a changed code while gs is held is a new event; gs falling is not.
   assign new_evt = gs & (~gs_q | (code != code_q));
   assign pop     = evt_valid & evt_ready;
   assign drop    = new_evt & full & ~pop;

   dvsd_pe_evq_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (new_evt),
      .pop   (pop),
      .din   (code),
      .dout  (evt_code),
      .valid (evt_valid),
      .full  (full),
      .level (level)
   );

   always_comb begin
      code_d = code;
      gs_d   = gs;
      idle_d = eno;
      ovf_d  = ovf_q;
      if (ovf_clr) begin
         ovf_d = 1'b0;
      end else if (drop) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_q <= '0;
         gs_q   <= 1'b0;
         idle_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         code_q <= code_d;
         gs_q   <= gs_d;
         idle_q <= idle_d;
         ovf_q  <= ovf_d;
      end
   end

   assign idle = idle_q;
   assign ovf  = ovf_q;

`ifdef DVSD_PE_EVQ_OVF_CNT_EN
   logic [7:0] ovf_cnt_q, ovf_cnt_d;

   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (ovf_clr) begin
         ovf_cnt_d = 8'd0;
      end else if (drop) begin
         ovf_cnt_d = sat_inc8(ovf_cnt_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_cnt_q <= 8'd0;
      end else begin
         ovf_cnt_q <= ovf_cnt_d;
      end
   end

   assign ovf_cnt = ovf_cnt_q;
`else
   assign ovf_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_dvsd_pe_evq.sv
// Randomised and directed bench for dvsd_pe_evq against a queue-based behavioural model.
module tb_dvsd_pe_evq;
   localparam int DEPTH = 4;
`ifdef DVSD_PE_EVQ_OVF_CNT_EN
   localparam int CNT_ON = 1;
`else
   localparam int CNT_ON = 0;
`endif

   logic                   clk;
   logic                   rst_n;
   logic [2:0]             code;
   logic                   gs;
   logic                   eno;
   logic                   evt_valid;
   logic                   evt_ready;
   logic [2:0]             evt_code;
   logic [$clog2(DEPTH):0] level;
   logic                   idle;
   logic                   ovf;
   logic                   ovf_clr;
   logic [7:0]             ovf_cnt;

   dvsd_pe_evq #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .code      (code),
      .gs        (gs),
      .eno       (eno),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_code  (evt_code),
      .level     (level),
      .idle      (idle),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr),
      .ovf_cnt   (ovf_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural model state
   int q[$];
   bit m_gs;
   int m_code;
   bit m_idle;
   bit m_ovf;
   int m_cnt;

   int total = 0;
   int bad   = 0;

   // literal expectations posted by the directed sequence (-1 = don't care)
   int pin_seq  = 0;
   int seen_seq = 0;
   int pin_lvl, pin_vld, pin_code, pin_ovf, pin_cnt, pin_idle;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_gs   = 1'b0;
         m_code = 0;
         m_idle = 1'b0;
         m_ovf  = 1'b0;
         m_cnt  = 0;
      end else begin
         bit nev, pp, dr;
         nev = gs && (!m_gs || int'(code) != m_code);
         pp  = evt_ready && (q.size() > 0);
         dr  = nev && (q.size() == DEPTH) && !pp;
         if (pp) void'(q.pop_front());
         if (nev && !dr) q.push_back(int'(code));
         if (ovf_clr) begin
            m_ovf = 1'b0;
            m_cnt = 0;
         end else if (dr) begin
            m_ovf = 1'b1;
            if (m_cnt < 255) m_cnt = m_cnt + 1;
         end
         m_idle = eno;
         m_gs   = gs;
         m_code = int'(code);
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("evt_valid", int'(evt_valid), (q.size() > 0) ? 1 : 0);
      chk("evt_code",  int'(evt_code),  (q.size() > 0) ? q[0] : 0);
      chk("level",     int'(level),     q.size());
      chk("idle",      int'(idle),      int'(m_idle));
      chk("ovf",       int'(ovf),       int'(m_ovf));
      chk("ovf_cnt",   int'(ovf_cnt),   CNT_ON ? m_cnt : 0);
      if (pin_seq != seen_seq) begin
         seen_seq = pin_seq;
         if (pin_lvl  >= 0) chk("pin_level",     int'(level),     pin_lvl);
         if (pin_vld  >= 0) chk("pin_evt_valid", int'(evt_valid), pin_vld);
         if (pin_code >= 0) chk("pin_evt_code",  int'(evt_code),  pin_code);
         if (pin_ovf  >= 0) chk("pin_ovf",       int'(ovf),       pin_ovf);
         if (pin_cnt  >= 0) chk("pin_ovf_cnt",   int'(ovf_cnt),   pin_cnt);
         if (pin_idle >= 0) chk("pin_idle",      int'(idle),      pin_idle);
      end
   end

   task automatic pin(input int l, input int v, input int c, input int o, input int n, input int i);
      pin_lvl  = l;
      pin_vld  = v;
      pin_code = c;
      pin_ovf  = o;
      pin_cnt  = n;
      pin_idle = i;
      pin_seq++;
   endtask

   task automatic drive(input bit g, input int c, input bit r, input bit e, input bit clr);
      @(negedge clk);
      gs        = g;
      code      = 3'(c);
      evt_ready = r;
      eno       = e;
      ovf_clr   = clr;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      gs = 1'b0; code = '0; evt_ready = 1'b0; eno = 1'b0; ovf_clr = 1'b0;
      pin(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // single held request: one event, visible one cycle after gs rises
      drive(1, 5, 0, 0, 0);
      after_edge();
      pin(1, 1, 5, 0, -1, 0);
      repeat (9) drive(1, 5, 0, 0, 0);
      after_edge();
      pin(1, 1, 5, 0, -1, 0);

      // drain with encoder idle
      repeat (3) drive(0, 5, 1, 1, 0);
      after_edge();
      pin(0, 0, 0, -1, -1, 1);

      // priority walk
      for (int c = 0; c < 8; c++) drive(1, c, 1, 0, 0);
      repeat (3) drive(0, 7, 1, 1, 0);

      // overflow: 1..4 kept, 5 and 6 dropped
      for (int c = 1; c <= 6; c++) drive(1, c, 0, 0, 0);
      after_edge();
      pin(4, 1, 1, 1, CNT_ON ? 2 : 0, 0);
      drive(1, 6, 0, 0, 1);
      after_edge();
      pin(4, 1, 1, 0, 0, -1);

      // full with simultaneous push and pop
      drive(1, 7, 1, 0, 0);
      after_edge();
      pin(4, 1, 2, 0, 0, -1);

      // gs 1->0->1 on the same code gives two events
      repeat (6) drive(0, 0, 1, 1, 0);
      drive(1, 3, 0, 0, 0);
      drive(0, 3, 0, 1, 0);
      drive(1, 3, 0, 0, 0);
      drive(0, 3, 0, 1, 0);
      after_edge();
      pin(2, 1, 3, 0, 0, 1);

      // asynchronous reset with three entries queued
      repeat (4) drive(0, 0, 1, 1, 0);
      drive(1, 1, 0, 0, 0);
      drive(1, 2, 0, 0, 0);
      drive(1, 3, 0, 0, 0);
      after_edge();
      pin(3, 1, 1, 0, 0, 0);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      pin(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // randomised traffic
      for (int i = 0; i < 3000; i++) begin
         bit g, r, e, clr;
         int c;
         g   = ($urandom_range(3, 0) != 0);
         c   = ($urandom_range(2, 0) == 0) ? int'($urandom_range(7, 0)) : int'(code);
         r   = ($urandom_range(1, 0) == 1);
         e   = !g && ($urandom_range(1, 0) == 1);
         clr = ($urandom_range(15, 0) == 0);
         drive(g, c, r, e, clr);
      end
      drive(0, 0, 1, 1, 0);
      repeat (2) @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
